// File: rtl/ysyx_24110015_lsu_if.sv
// Bundle for the LSU: execute-stage input handshake, write-back output handshake and memory bus.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface ysyx_24110015_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_func3;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [31:0] in_pass_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_misalign;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_func3, in_mem_read, in_mem_write, in_pass_data,
        output in_ready,
        output out_valid, out_data, out_misalign,
        input  out_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_func3, in_mem_read, in_mem_write, in_pass_data,
        input  in_ready,
        input  out_valid, out_data, out_misalign,
        output out_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: one access per handshake over a request/response bus, byte-lane aligned,
// with load extension, misalignment trapping and single-cycle passthrough for non-memory ops.
module ysyx_24110015_lsu (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_24110015_lsu_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_func3;
    logic [1:0]  r_off;
    logic        r_is_load;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_misalign;
    logic        r_mem_req_valid;
    logic [31:0] r_mem_addr;
    logic        r_mem_wen;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;

    logic        w_is_mem;
    logic        w_misalign;

    function automatic logic misaligned(input logic [2:0] f, input logic [1:0] o);
        case (f[1:0])
            2'b01:   misaligned = o[0];
            2'b10:   misaligned = (o != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f, input logic [1:0] o);
        case (f)
            3'b000:  store_mask = 4'b0001 << o;
            3'b001:  store_mask = 4'b0011 << o;
            3'b010:  store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign/zero extend by access width.
    function automatic logic [31:0] load_extend(input logic [2:0] f, input logic [31:0] word,
                                                input logic [1:0] o);
        logic [31:0] s;
        s = word >> {o, 3'b000};
        case (f)
            3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
            3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
            3'b010:  load_extend = s;
            3'b100:  load_extend = {24'h000000, s[7:0]};
            3'b101:  load_extend = {16'h0000, s[15:0]};
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

    assign w_is_mem   = bus.in_mem_read | bus.in_mem_write;
    assign w_misalign = misaligned(bus.in_func3, bus.in_addr[1:0]);

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_misalign  = r_out_misalign;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wen       = r_mem_wen;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.mem_wmask     = r_mem_wmask;

    // Transaction FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_func3         <= 3'b000;
            r_off           <= 2'b00;
            r_is_load       <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= 32'h0000_0000;
            r_out_misalign  <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= 32'h0000_0000;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= 32'h0000_0000;
            r_mem_wmask     <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_func3   <= bus.in_func3;
                        r_off     <= bus.in_addr[1:0];
                        r_is_load <= bus.in_mem_read;
                        if (!w_is_mem) begin
                            r_out_data  <= bus.in_pass_data;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_misalign) begin
                            r_out_data     <= bus.in_addr;
                            r_out_misalign <= 1'b1;
                            r_out_valid    <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            // Read wins when both flags are set: issued as a plain load.
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {bus.in_addr[31:2], 2'b00};
                            r_mem_wen       <= ~bus.in_mem_read;
                            r_mem_wdata     <= bus.in_mem_read ? 32'h0000_0000
                                             : (bus.in_wdata << {bus.in_addr[1:0], 3'b000});
                            r_mem_wmask     <= bus.in_mem_read ? 4'b0000
                                             : store_mask(bus.in_func3, bus.in_addr[1:0]);
                            r_state         <= S_REQ;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        r_out_data  <= r_is_load ? load_extend(r_func3, bus.mem_rdata, r_off)
                                                 : 32'h0000_0000;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid    <= 1'b0;
                        r_out_misalign <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Randomized bench for the LSU: directed cases first, then random transactions with random
// bus/write-back backpressure, all checked against an arithmetic reference model.
module tb_ysyx_24110015_lsu;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ysyx_24110015_lsu_if bus ();

    ysyx_24110015_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int f, input logic [31:0] rdata, input int off);
        logic [31:0] sh;
        int b;
        sh = rdata >> (8 * off);
        case (f)
            0: begin b = int'(sh & 32'h0000_00FF); return 32'(b >= 128 ? b - 256 : b); end
            1: begin b = int'(sh & 32'h0000_FFFF); return 32'(b >= 32768 ? b - 65536 : b); end
            2: return sh;
            4: return sh & 32'h0000_00FF;
            5: return sh & 32'h0000_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] ref_mask(input int f, input int off);
        case (f)
            0: return 4'(1 << off);
            1: return 4'(3 << off);
            2: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit ref_mis(input int f, input int off);
        return ((f % 4) == 1 && (off % 2) != 0) || ((f % 4) == 2 && off != 0);
    endfunction

    task automatic check_done(input logic [31:0] exp_data, input logic exp_mis, input int out_dly);
        check("out_valid", bus.out_valid, 32'd1);
        check("out_data", bus.out_data, exp_data);
        check("out_misalign", bus.out_misalign, exp_mis);
        check("in_ready_busy", bus.in_ready, 32'd0);
        for (int i = 0; i < out_dly; i++) begin
            @(negedge clk);
            check("out_valid_hold", bus.out_valid, 32'd1);
            check("out_data_hold", bus.out_data, exp_data);
            check("out_mis_hold", bus.out_misalign, exp_mis);
            check("in_ready_hold", bus.in_ready, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_clr", bus.out_valid, 32'd0);
        check("out_mis_clr", bus.out_misalign, 32'd0);
        check("in_ready_back", bus.in_ready, 32'd1);
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input int f3,
                          input bit rd, input bit wr, input logic [31:0] pass,
                          input logic [31:0] rdata, input int req_dly, input int rsp_dly,
                          input int out_dly, input bit rsp_with_ready);
        int off;
        bit is_mem;
        bit mis;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
        off    = int'(addr & 32'd3);
        is_mem = rd || wr;
        mis    = is_mem && ref_mis(f3, off);
        exp_wdata = wdata << (8 * off);
        check("in_ready_idle", bus.in_ready, 32'd1);
        bus.in_valid     = 1'b1;
        bus.in_addr      = addr;
        bus.in_wdata     = wdata;
        bus.in_func3     = 3'(f3);
        bus.in_mem_read  = rd;
        bus.in_mem_write = wr;
        bus.in_pass_data = pass;
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.in_addr      = $urandom;
        bus.in_wdata     = $urandom;
        bus.in_pass_data = $urandom;
        bus.in_func3     = 3'($urandom_range(0, 7));
        if (!is_mem || mis) begin
            check("no_req", bus.mem_req_valid, 32'd0);
            check_done(is_mem ? addr : pass, mis, out_dly);
        end else begin
            for (int i = 0; i <= req_dly; i++) begin
                if (i > 0) @(negedge clk);
                check("req_valid", bus.mem_req_valid, 32'd1);
                check("req_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                check("req_wen", bus.mem_wen, rd ? 32'd0 : 32'd1);
                if (!rd) begin
                    check("req_wdata", bus.mem_wdata, exp_wdata);
                    check("req_wmask", bus.mem_wmask, ref_mask(f3, off));
                end
                check("req_in_ready", bus.in_ready, 32'd0);
                check("req_no_out", bus.out_valid, 32'd0);
            end
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = rsp_with_ready;
            bus.mem_rdata     = $urandom;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            check("req_dropped", bus.mem_req_valid, 32'd0);
            check("wait_no_out", bus.out_valid, 32'd0);
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                check("wait_hold", bus.out_valid, 32'd0);
            end
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = rdata;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rdata     = $urandom;
            exp_data = rd ? ref_load(f3, rdata, off) : 32'h0000_0000;
            check_done(exp_data, 1'b0, out_dly);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_addr = 32'd0; bus.in_wdata = 32'd0; bus.in_func3 = 3'd0;
        bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.in_pass_data = 32'd0;
        bus.out_ready = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 32'd1);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_req_valid", bus.mem_req_valid, 32'd0);
        check("rst_wmask", bus.mem_wmask, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_txn(32'h8000_0000, 32'h0, 0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0003, 32'h0, 0, 1'b1, 1'b0, 32'h0, 32'h80FF_0000, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0003, 32'h0, 4, 1'b1, 1'b0, 32'h0, 32'h80FF_0000, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0002, 32'h0, 1, 1'b1, 1'b0, 32'h0, 32'h80FF_0000, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0102, 32'hAAAA_BEEF, 1, 1'b0, 1'b1, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0001, 32'h0, 2, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0003, 32'h5555, 1, 1'b0, 1'b1, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        do_txn(32'h8000_0010, 32'h0, 2, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 5, 3, 4, 1'b0);
        do_txn(32'h8000_0011, 32'h0, 7, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 0, 1, 0, 1'b1);

        // Reset while waiting for a response; the late response must be ignored.
        bus.in_valid = 1'b1; bus.in_addr = 32'h8000_0020; bus.in_func3 = 3'd2;
        bus.in_mem_read = 1'b1; bus.in_mem_write = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 32'd1);
        check("mid_rst_req", bus.mem_req_valid, 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'd0);
        check("mid_rst_out", bus.out_valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("late_rsp_out", bus.out_valid, 32'd0);
        check("late_rsp_data", bus.out_data, 32'd0);
        check("late_rsp_ready", bus.in_ready, 32'd1);
        do_txn(32'h8000_0024, 32'h0, 5, 1'b1, 1'b0, 32'h0, 32'h1234_8765, 1, 1, 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 3));
            do_txn($urandom, $urandom, int'($urandom_range(0, 7)), op == 1 || op == 3, op >= 2,
                   $urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
